// File: rtl/rot_offset_gen_pkg.sv
// Shared constants and state encoding for the rotated sample-offset generator.
// Rotates a WIN x WIN sample grid about its centre by one of 32 orientation bins.
package rot_offset_gen_pkg;

  localparam int WIN    = 16;  // descriptor window side, power of two
  localparam int CF     = 7;   // fractional bits of the Q1.CF coefficients
  localparam int COEF_W = 9;   // signed coefficient width, holds +/-128
  localparam int OFF_W  = 6;   // signed rotated offset width
  localparam int PROD_W = 15;  // product and sum width, no overflow possible
  localparam int ORI_W  = 5;
  localparam int IDX_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

endpackage

// File: rtl/sincos_lut.sv
// Combinational cos/sin table for 32 orientation bins of 11.25 degrees,
// values round(128*cos), round(128*sin), counter-clockwise.
module sincos_lut
  import rot_offset_gen_pkg::*;
(
  input  logic        [ORI_W-1:0]  ori,
  output logic signed [COEF_W-1:0] cos_val,
  output logic signed [COEF_W-1:0] sin_val
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    cos_val = '0;
    sin_val = '0;
    case (ori)
      5'd0:  {cos_val, sin_val} = {9'sd128,  9'sd0};
      5'd1:  {cos_val, sin_val} = {9'sd126,  9'sd25};
      5'd2:  {cos_val, sin_val} = {9'sd118,  9'sd49};
      5'd3:  {cos_val, sin_val} = {9'sd106,  9'sd71};
      5'd4:  {cos_val, sin_val} = {9'sd91,   9'sd91};
      5'd5:  {cos_val, sin_val} = {9'sd71,   9'sd106};
      5'd6:  {cos_val, sin_val} = {9'sd49,   9'sd118};
      5'd7:  {cos_val, sin_val} = {9'sd25,   9'sd126};
      5'd8:  {cos_val, sin_val} = {9'sd0,    9'sd128};
      5'd9:  {cos_val, sin_val} = {-9'sd25,  9'sd126};
      5'd10: {cos_val, sin_val} = {-9'sd49,  9'sd118};
      5'd11: {cos_val, sin_val} = {-9'sd71,  9'sd106};
      5'd12: {cos_val, sin_val} = {-9'sd91,  9'sd91};
      5'd13: {cos_val, sin_val} = {-9'sd106, 9'sd71};
      5'd14: {cos_val, sin_val} = {-9'sd118, 9'sd49};
      5'd15: {cos_val, sin_val} = {-9'sd126, 9'sd25};
      5'd16: {cos_val, sin_val} = {-9'sd128, 9'sd0};
      5'd17: {cos_val, sin_val} = {-9'sd126, -9'sd25};
      5'd18: {cos_val, sin_val} = {-9'sd118, -9'sd49};
      5'd19: {cos_val, sin_val} = {-9'sd106, -9'sd71};
      5'd20: {cos_val, sin_val} = {-9'sd91,  -9'sd91};
      5'd21: {cos_val, sin_val} = {-9'sd71,  -9'sd106};
      5'd22: {cos_val, sin_val} = {-9'sd49,  -9'sd118};
      5'd23: {cos_val, sin_val} = {-9'sd25,  -9'sd126};
      5'd24: {cos_val, sin_val} = {9'sd0,    -9'sd128};
      5'd25: {cos_val, sin_val} = {9'sd25,   -9'sd126};
      5'd26: {cos_val, sin_val} = {9'sd49,   -9'sd118};
      5'd27: {cos_val, sin_val} = {9'sd71,   -9'sd106};
      5'd28: {cos_val, sin_val} = {9'sd91,   -9'sd91};
      5'd29: {cos_val, sin_val} = {9'sd106,  -9'sd71};
      5'd30: {cos_val, sin_val} = {9'sd118,  -9'sd49};
      5'd31: {cos_val, sin_val} = {9'sd126,  -9'sd25};
      default: ;
    endcase
  end

endmodule

// File: rtl/rot_offset_gen.sv
// Sweeps every sample of the window in raster order and emits its offset from
// the centre rotated by the captured orientation, through a 2-stage stallable pipe.
module rot_offset_gen #(
  parameter int WIN = rot_offset_gen_pkg::WIN,
  parameter int CF  = rot_offset_gen_pkg::CF
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start,
  input  logic        [rot_offset_gen_pkg::ORI_W-1:0] ori,
  output logic                                        busy,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic        [rot_offset_gen_pkg::IDX_W-1:0] out_idx,
  output logic signed [rot_offset_gen_pkg::OFF_W-1:0] out_dx,
  output logic signed [rot_offset_gen_pkg::OFF_W-1:0] out_dy,
  output logic                                        out_last,
  output logic                                        done
);
  import rot_offset_gen_pkg::*;

  localparam int                        LOG_W    = $clog2(WIN);
  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(WIN * WIN - 1);
  localparam logic signed [LOG_W:0]     HALF     = (LOG_W + 1)'(WIN / 2);
  localparam logic signed [PROD_W-1:0]  RND      = PROD_W'(1 << (CF - 1));

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [COEF_W-1:0]  cos_q, cos_d, sin_q, sin_d;
  logic                      busy_q, busy_d, done_q, done_d;
  logic                      s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0]          s1_idx_q, s1_idx_d;
  logic signed [PROD_W-1:0]  p_xc_q, p_xc_d, p_ys_q, p_ys_d;
  logic signed [PROD_W-1:0]  p_xs_q, p_xs_d, p_yc_q, p_yc_d;
  logic                      out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [IDX_W-1:0]          out_idx_q, out_idx_d;
  logic signed [OFF_W-1:0]   out_dx_q, out_dx_d, out_dy_q, out_dy_d;

  logic signed [COEF_W-1:0]  lut_cos, lut_sin;
  logic signed [LOG_W:0]     x, y;
  logic signed [PROD_W-1:0]  x_w, y_w, c_w, s_w, rx, ry;
  logic                      en;

  sincos_lut u_lut (
    .ori     (ori),
    .cos_val (lut_cos),
    .sin_val (lut_sin)
  );

  assign en  = !out_valid_q || out_ready;
  assign x   = $signed({1'b0, idx_q[LOG_W-1:0]}) - HALF;
  assign y   = $signed({1'b0, idx_q[IDX_W-1:LOG_W]}) - HALF;
  assign x_w = PROD_W'(x);
  assign y_w = PROD_W'(y);
  assign c_w = PROD_W'(cos_q);
  assign s_w = PROD_W'(sin_q);
  assign rx  = p_xc_q - p_ys_q;
  assign ry  = p_xs_q + p_yc_q;

  always_comb begin
    // NOTE: combinational logic uses blocking '='; only always_ff uses '<='.
    state_d     = state_q;
    idx_d       = idx_q;
    cos_d       = cos_q;
    sin_d       = sin_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    s1_valid_d  = s1_valid_q;
    s1_idx_d    = s1_idx_q;
    p_xc_d      = p_xc_q;
    p_ys_d      = p_ys_q;
    p_xs_d      = p_xs_q;
    p_yc_d      = p_yc_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    out_dx_d    = out_dx_q;
    out_dy_d    = out_dy_q;

    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        idx_d   = '0;
        cos_d   = lut_cos;
        sin_d   = lut_sin;
        busy_d  = 1'b1;
      end
      RUN: if (en) begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: if (out_valid_q && out_ready && out_last_q) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (en) begin
      s1_valid_d = (state_q == RUN);
      if (state_q == RUN) begin
        s1_idx_d = idx_q;
        p_xc_d   = x_w * c_w;
        p_ys_d   = y_w * s_w;
        p_xs_d   = x_w * s_w;
        p_yc_d   = y_w * c_w;
      end
      out_valid_d = s1_valid_q;
      out_last_d  = s1_valid_q && (s1_idx_q == LAST_IDX);
      if (s1_valid_q) begin
        out_idx_d = s1_idx_q;
        out_dx_d  = OFF_W'((rx + RND) >>> CF);
        out_dy_d  = OFF_W'((ry + RND) >>> CF);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cos_q       <= '0;
      sin_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      out_dx_q    <= '0;
      out_dy_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cos_q       <= cos_d;
      sin_q       <= sin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      out_dx_q    <= out_dx_d;
      out_dy_q    <= out_dy_d;
    end
  end

  // NOTE: stage-1 data needs no reset; s1_valid_q qualifies every use of it.
  always_ff @(posedge clk) begin
    s1_idx_q <= s1_idx_d;
    p_xc_q   <= p_xc_d;
    p_ys_q   <= p_ys_d;
    p_xs_q   <= p_xs_d;
    p_yc_q   <= p_yc_d;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;
  assign out_dx    = out_dx_q;
  assign out_dy    = out_dy_q;

endmodule
